datapath_unit: RTL and testbench

//  Register/ALU datapath executed by the control FSM: consumes its per-cycle control word
//  (wen, wsel, asel, bsel, datasel, alusel, resReg) and returns the eq status it branches on.

---
 rtl/datapath_unit.sv | 141 ++++++++++++++
 tb/tb_datapath_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
// datapath_unit
//   Register/ALU datapath driven by a per-cycle control word from the control FSM.
//   It holds three writable registers R0..R2 and a read-only constant register R3.
//   It has a two-operand ALU and a combinational R0 == R1 comparator.
//   It also keeps a sticky overflow flag and a saturating write counter for debug.
// Ports
//   clk            system clock; all state updates on the rising edge
//   resDatapath_n  asynchronous active-low reset
//   wen[1:0]       [1] writes R0; [0] writes R1 (wsel=0) or R2 (wsel=1)
//   wsel           destination select for wen[0]
//   asel, bsel     ALU operand A/B source register (R0..R3)
//   datasel        write-data source: 1 = data_in, 0 = ALU result
//   alusel         00 pass B, 01 A+B, 10 A<<1, 11 A-B
//   resReg[2:0]    synchronous clear; bit i clears Ri
//   data_in        external operand
//   eq             combinational R0 == R1
//   data_out       current R0
//   ovf            sticky ALU carry/borrow/shift-out flag
//   wr_count       saturating count of cycles with any write enable set
module datapath_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CONST_B = 1,
  parameter int unsigned CNTW    = 8
) (
  input  logic             clk,
  input  logic             resDatapath_n,
  input  logic [1:0]       wen,
  input  logic             wsel,
  input  logic [1:0]       asel,
  input  logic [1:0]       bsel,
  input  logic             datasel,
  input  logic [1:0]       alusel,
  input  logic [2:0]       resReg,
  input  logic [WIDTH-1:0] data_in,
  output logic             eq,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic [CNTW-1:0]  wr_count
);

  localparam logic [WIDTH-1:0] R3_VAL = WIDTH'(CONST_B);

  logic [WIDTH-1:0] r0, r1, r2;
  logic [WIDTH-1:0] op_a, op_b, alu_out, wdata;
  logic [WIDTH:0]   sum_ext;
  logic             alu_carry;

  always_comb begin
    op_a = R3_VAL;
    unique case (asel)
      2'd0:    op_a = r0;
      2'd1:    op_a = r1;
      2'd2:    op_a = r2;
      default: op_a = R3_VAL;
    endcase
  end

  always_comb begin
    op_b = R3_VAL;
    unique case (bsel)
      2'd0:    op_b = r0;
      2'd1:    op_b = r1;
      2'd2:    op_b = r2;
      default: op_b = R3_VAL;
    endcase
  end

  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    alu_out   = op_b;
    alu_carry = 1'b0;
    unique case (alusel)
      2'b00: begin
        alu_out   = op_b;
        alu_carry = 1'b0;
      end
      2'b01: begin
        alu_out   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      2'b10: begin
        alu_out   = op_a << 1;
        alu_carry = op_a[WIDTH-1];
      end
      default: begin
        alu_out   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
    endcase
  end

  assign wdata = datasel ? data_in : alu_out;

  // Clear has priority over write for each register independently.
  always_ff @(posedge clk or negedge resDatapath_n) begin
    if (!resDatapath_n) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      if (resReg[0])
        r0 <= '0;
      else if (wen[1])
        r0 <= wdata;

      if (resReg[1])
        r1 <= '0;
      else if (wen[0] && !wsel)
        r1 <= wdata;

      if (resReg[2])
        r2 <= '0;
      else if (wen[0] && wsel)
        r2 <= wdata;
    end
  end

  // Overflow only counts when the ALU result is actually being written.
  always_ff @(posedge clk or negedge resDatapath_n) begin
    if (!resDatapath_n)
      ovf <= 1'b0;
    else if (resReg[0])
      ovf <= 1'b0;
    else if ((|wen) && !datasel && alu_carry)
      ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge resDatapath_n) begin
    if (!resDatapath_n)
      wr_count <= '0;
    else if (resReg == 3'b111)
      wr_count <= '0;
    else if ((|wen) && (wr_count != '1))
      wr_count <= wr_count + 1'b1;
  end

  assign eq       = (r0 == r1);
  assign data_out = r0;

endmodule

// File: tb/tb_datapath_unit.sv
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wen;
  logic       wsel;
  logic [1:0] asel, bsel;
  logic       datasel;
  logic [1:0] alusel;
  logic [2:0] resReg;
  logic [7:0] data_in;
  logic       eq;
  logic [7:0] data_out;
  logic       ovf;
  logic [7:0] wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dout;
    logic       eq;
    logic       ovf;
    logic [7:0] cnt;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   step_id = 0;

  datapath_unit #(.WIDTH(8), .CONST_B(1), .CNTW(8)) dut (
    .clk           (clk),
    .resDatapath_n (rst_n),
    .wen           (wen),
    .wsel          (wsel),
    .asel          (asel),
    .bsel          (bsel),
    .datasel       (datasel),
    .alusel        (alusel),
    .resReg        (resReg),
    .data_in       (data_in),
    .eq            (eq),
    .data_out      (data_out),
    .ovf           (ovf),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (data_out !== e.dout || eq !== e.eq || ovf !== e.ovf || wr_count !== e.cnt) begin
      errors++;
      $display("FAIL %s%0d: got dout=%02h eq=%0b ovf=%0b cnt=%02h, want dout=%02h eq=%0b ovf=%0b cnt=%02h",
               name, e.id, data_out, eq, ovf, wr_count, e.dout, e.eq, e.ovf, e.cnt);
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compare("step", e);
    end
  end

  // Drives one control word at the falling edge and queues the state expected after the next rising edge.
  task automatic step(input logic [1:0] w, input logic ws, input logic [1:0] a, input logic [1:0] b,
                      input logic ds, input logic [1:0] al, input logic [2:0] rr, input logic [7:0] din,
                      input logic [7:0] e_dout, input logic e_eq, input logic e_ovf, input logic [7:0] e_cnt);
    exp_t e;
    wen = w; wsel = ws; asel = a; bsel = b; datasel = ds; alusel = al; resReg = rr; data_in = din;
    step_id++;
    e.dout = e_dout; e.eq = e_eq; e.ovf = e_ovf; e.cnt = e_cnt; e.id = step_id;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [7:0] e_dout, input logic e_eq,
                           input logic e_ovf, input logic [7:0] e_cnt);
    exp_t e;
    e.dout = e_dout; e.eq = e_eq; e.ovf = e_ovf; e.cnt = e_cnt; e.id = 0;
    compare(name, e);
  endtask

  initial begin
    rst_n = 1'b0;
    wen = 2'b00; wsel = 1'b0; asel = 2'd0; bsel = 2'd0;
    datasel = 1'b0; alusel = 2'b00; resReg = 3'b000; data_in = 8'h00;
    #12;
    check_now("reset_init", 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    //     wen   ws    a     b     ds    alu    rr      din    dout   eq    ovf   cnt
    step(2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'b000, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0);   // idle
    step(2'b11, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h05, 8'h05, 1'b1, 1'b0, 8'd1);   // load R0=R1=5
    step(2'b10, 1'b0, 2'd0, 2'd3, 1'b0, 2'b01, 3'b000, 8'h00, 8'h06, 1'b0, 1'b0, 8'd2);   // R0+R3

    // Asynchronous reset pulse while clk is high
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("reset_async", 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b11, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h05, 8'h05, 1'b1, 1'b0, 8'd1);   // first write after reset
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'd2);   // R0=F0
    step(2'b01, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h20, 8'hF0, 1'b0, 1'b0, 8'd3);   // R1=20
    step(2'b10, 1'b0, 2'd0, 2'd1, 1'b0, 2'b01, 3'b000, 8'h00, 8'h10, 1'b0, 1'b1, 8'd4);   // F0+20 carry
    step(2'b10, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'b000, 8'h00, 8'h20, 1'b1, 1'b1, 8'd5);   // pass B, ovf sticky
    step(2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, 8'd5);   // clear R0 + ovf
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'd6);   // R0=FF
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b0, 2'b01, 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, 8'd7);   // clear beats write+ovf set
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h81, 8'h81, 1'b0, 1'b0, 8'd8);   // R0=81
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b0, 2'b10, 3'b000, 8'h00, 8'h02, 1'b0, 1'b1, 8'd9);   // shift-out
    step(2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, 8'd9);   // clear
    step(2'b11, 1'b1, 2'd0, 2'd0, 1'b1, 2'b00, 3'b100, 8'h33, 8'h33, 1'b0, 1'b0, 8'd10);  // R0=33, R2 cleared
    step(2'b10, 1'b0, 2'd0, 2'd2, 1'b0, 2'b00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 8'd11);  // R0=R2 shows 0
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b111, 8'h44, 8'h00, 1'b1, 1'b0, 8'd0);   // clear all + count
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h02, 8'h02, 1'b0, 1'b0, 8'd1);   // R0=2
    step(2'b01, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h03, 8'h02, 1'b0, 1'b0, 8'd2);   // R1=3
    step(2'b10, 1'b0, 2'd0, 2'd1, 1'b0, 2'b11, 3'b000, 8'h00, 8'hFF, 1'b0, 1'b1, 8'd3);   // 2-3 borrow

    // Write only R2 from data_in until the counter saturates (300 writes in total)
    for (int i = 4; i <= 300; i++) begin
      step(2'b01, 1'b1, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h00, 8'hFF, 1'b0, 1'b1,
           (i > 255) ? 8'hFF : 8'(i));
    end
    step(2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'b000, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF);  // idle holds
    step(2'b10, 1'b0, 2'd3, 2'd3, 1'b0, 2'b01, 3'b000, 8'h00, 8'h02, 1'b0, 1'b1, 8'hFF);  // R3+R3
    step(2'b10, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'b000, 8'h03, 8'h03, 1'b1, 1'b1, 8'hFF);  // R0=3 == R1
    step(2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'b010, 8'h00, 8'h03, 1'b0, 1'b1, 8'hFF);  // clear R1 only

    wen = 2'b00; resReg = 3'b000; datasel = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
